// File: rtl/snake_fmap_packer_if.sv
// Pixel-stream / SRAM-write bundle for snake_fmap_packer.
// Optional stall_cnt member appears when FMAP_STALL_CNT_EN is defined.
interface snake_fmap_packer_if #(
   parameter int DATA_W = 8,
   parameter int CH     = 16,
   parameter int ADDR_W = 12
);
   logic                     start;
   logic                     abort;
   logic                     in_valid;
   logic                     in_ready;
   logic [CH*DATA_W-1:0]     in_data;
   logic                     busy;
   logic                     done;
   logic                     row_done;
   logic                     dir;
   logic                     cen;
   logic [CH-1:0]            wen;
   logic [ADDR_W-1:0]        addr;
   logic [CH*2*DATA_W-1:0]   d;

`ifdef FMAP_STALL_CNT_EN
   logic [15:0]              stall_cnt;

   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, busy, done, row_done, dir, cen, wen, addr, d, stall_cnt
   );
   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, busy, done, row_done, dir, cen, wen, addr, d, stall_cnt
   );
`else
   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, busy, done, row_done, dir, cen, wen, addr, d
   );
   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, busy, done, row_done, dir, cen, wen, addr, d
   );
`endif
endinterface

// File: rtl/snake_fmap_packer.sv
// Packs snake-ordered pixel pairs into CH-bank SRAM words (two pixels per bank word).
// Define FMAP_STALL_CNT_EN to add the 16-bit saturating stall_cnt output.
module snake_fmap_packer #(
   parameter int DATA_W = 8,
   parameter int CH     = 16,
   parameter int COLS   = 16,
   parameter int ROWS   = 256,
   parameter int ADDR_W = 12,
   parameter int ORDER  = 0
) (
   input logic               clk,
   input logic               rst_n,
   snake_fmap_packer_if.slave bus
);
   localparam int HALF   = COLS / 2;
   localparam int PAIR_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, LO, HI, LAST} state_t;

   state_t                 state_q, state_d;
   logic [CH*DATA_W-1:0]   first_q;
   logic [PAIR_W-1:0]      pair_q;
   logic [ROW_W-1:0]       row_q;
   logic [ADDR_W-1:0]      base_q;
   logic                   dir_q;
   logic                   cen_q;
   logic [CH-1:0]          wen_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [CH*2*DATA_W-1:0] d_q;
   logic                   row_done_q;

   logic                   hi_acc;
   logic                   row_end;
   logic                   frame_end;
   logic                   swap;
   logic [ADDR_W-1:0]      wr_addr;
   logic [CH*2*DATA_W-1:0] wr_data;

   assign hi_acc    = (state_q == HI) && bus.in_valid && !bus.abort;
   assign row_end   = (pair_q == PAIR_W'(HALF - 1));
   assign frame_end = row_end && (row_q == ROW_W'(ROWS - 1));
   // Column-ascending packing mirrors pair order on right-to-left rows.
   assign swap      = (ORDER == 1) && dir_q;
   assign wr_addr   = swap ? (base_q + ADDR_W'(HALF - 1) - ADDR_W'(pair_q))
                           : (base_q + ADDR_W'(pair_q));

   always_comb begin
      wr_data = '0;
      for (int k = 0; k < CH; k++) begin
         wr_data[k*2*DATA_W +: 2*DATA_W] = swap
            ? {bus.in_data[k*DATA_W +: DATA_W], first_q[k*DATA_W +: DATA_W]}
            : {first_q[k*DATA_W +: DATA_W], bus.in_data[k*DATA_W +: DATA_W]};
      end
   end

   // NOTE: every signal gets its default first, so no path through this block infers a latch.
   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start)    state_d = LO;
            LO:      if (bus.in_valid) state_d = HI;
            HI:      if (bus.in_valid) state_d = frame_end ? LAST : LO;
            LAST:                      state_d = IDLE;
            default:                   state_d = IDLE;
         endcase
      end
   end

   // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q    <= '0;
         pair_q     <= '0;
         row_q      <= '0;
         base_q     <= '0;
         dir_q      <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= '1;
         addr_q     <= '0;
         d_q        <= '0;
         row_done_q <= 1'b0;
      end else begin
         cen_q      <= 1'b1;
         wen_q      <= '1;
         row_done_q <= 1'b0;
         if (bus.abort || (state_q == IDLE && bus.start)) begin
            pair_q <= '0;
            row_q  <= '0;
            base_q <= '0;
            dir_q  <= 1'b0;
         end else if (state_q == LO && bus.in_valid) begin
            first_q <= bus.in_data;
         end else if (hi_acc) begin
            cen_q      <= 1'b0;
            wen_q      <= '0;
            addr_q     <= wr_addr;
            d_q        <= wr_data;
            row_done_q <= row_end;
            if (row_end) begin
               pair_q <= '0;
               dir_q  <= ~dir_q;
               if (frame_end) begin
                  row_q  <= '0;
                  base_q <= '0;
               end else begin
                  row_q  <= row_q + 1'b1;
                  base_q <= base_q + ADDR_W'(HALF);
               end
            end else begin
               pair_q <= pair_q + 1'b1;
            end
         end
      end
   end

`ifdef FMAP_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state_q == IDLE && bus.start && !bus.abort) begin
         stall_q <= '0;
      end else if ((state_q == LO || state_q == HI) && !bus.in_valid && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_q;
`endif

   assign bus.in_ready = (state_q == LO) || (state_q == HI);
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == LAST);
   assign bus.row_done = row_done_q;
   assign bus.dir      = dir_q;
   assign bus.cen      = cen_q;
   assign bus.wen      = wen_q;
   assign bus.addr     = addr_q;
   assign bus.d        = d_q;
endmodule

// File: doc/snake_fmap_packer.md
SNAKE_FMAP_PACKER -- requirements
Module: snake_fmap_packer

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter CH, default 16: channels per pixel beat; also the number of SRAM banks.
REQ-003 Parameter COLS, default 16: pixels per row; SHALL be even and >= 2.
REQ-004 Parameter ROWS, default 256: rows per frame; SHALL be >= 1.
REQ-005 Parameter ADDR_W, default 12: SRAM address width; SHALL be >= clog2(ROWS*COLS/2).
REQ-006 Parameter ORDER, default 0: 0 = arrival-order packing; 1 = column-ascending packing.
REQ-007 One clock; reset is asynchronous and active-low: clk (in, 1) and rst_n (in, 1).
REQ-008 start  in  1  single-cycle frame start request.
REQ-009 abort  in  1  synchronous frame cancel.
REQ-010 in_valid  in  1  a pixel beat is present on in_data.
REQ-011 in_ready  out  1  the block accepts a pixel beat this cycle.
REQ-012 in_data  in  CH*DATA_W  one pixel for all channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-013 busy  out  1  a frame is in progress.
REQ-014 done  out  1  one-cycle pulse marking frame completion.
REQ-015 row_done  out  1  one-cycle pulse on the write of each row's last word.
REQ-016 dir  out  1  direction of the current row: 0 = left-to-right, 1 = right-to-left.
REQ-017 cen  out  1  SRAM chip enable, active-low.
REQ-018 wen  out  CH  per-bank SRAM write enable, active-low.
REQ-019 addr  out  ADDR_W  SRAM word address.
REQ-020 d  out  CH*2*DATA_W  packed write data, bank k at bits [k*2*DATA_W +: 2*DATA_W].

Function
REQ-021 Pixels arrive in snake order: even rows in ascending column order, odd rows in descending column order.
REQ-022 The FSM SHALL have four states: IDLE, LO, HI and LAST.
REQ-023 IDLE to LO on start; LO to HI when a beat is accepted; HI to LO when a beat is accepted and it is not the frame's final beat; HI to LAST when the frame's final beat is accepted; LAST to IDLE unconditionally.
REQ-024 in_ready SHALL be 1 exactly in states LO and HI.
REQ-025 A beat is accepted when in_valid=1 and in_ready=1.
REQ-026 The beat accepted in LO is latched as "first"; the beat accepted in HI is "second".
REQ-027 Each accepted HI beat SHALL produce one write in the following cycle: cen=0, wen=all zeros, addr and d registered; in all other cycles cen=1 and wen=all ones.
REQ-028 ORDER=0: each bank word = {first, second}.
REQ-029 ORDER=0: addr = linear pair count, running 0 .. ROWS*COLS/2-1.
REQ-030 ORDER=1, even rows: bank word = {first, second}.
REQ-031 ORDER=1, odd rows: bank word = {second, first}, so the upper byte always holds the lower column.
REQ-032 ORDER=1, odd rows: addr = row*COLS/2 + (COLS/2-1-pair_in_row).
REQ-033 dir SHALL toggle at the row boundary, one cycle after the row's last accepted beat.
REQ-034 row_done SHALL coincide with the write of word COLS/2-1 of each row.
REQ-035 The LAST state SHALL issue the final write and pulse done=1 in the same cycle.
REQ-036 busy=1 in LO, HI and LAST.
REQ-037 start SHALL be ignored while busy=1.
REQ-038 abort SHALL take priority over every other input in all states: next state IDLE, no further writes, pair/row/address counters cleared, done not pulsed.
REQ-039 A write pending from a HI acceptance in the same cycle as abort SHALL be suppressed.
REQ-040 in_valid=0 in LO or HI holds state, counters and outputs; any number of stall cycles is allowed.

Reset
REQ-041 rst_n=0 SHALL force the following immediately, regardless of clk: state IDLE, in_ready=0, busy=0, done=0, row_done=0, dir=0, cen=1, wen=all ones, addr=0, d=0, all counters 0.
REQ-042 Reset mid-frame SHALL discard the partial frame.
REQ-043 Release of rst_n SHALL need no start-up cycles; a start on the first clock after release is honoured.

Configuration
REQ-044 Macro FMAP_STALL_CNT_EN, when defined, SHALL add output stall_cnt (out, 16 bits).
REQ-045 stall_cnt counts cycles with busy=1 and in_valid=0 in LO or HI.
REQ-046 stall_cnt clears on start and saturates at 16'hFFFF.
REQ-047 When FMAP_STALL_CNT_EN is undefined, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-048 CH=1, COLS=4, ROWS=2, ORDER=0; beats 11,12,13,14,24,23,22,21 back-to-back -> writes addr0=1112, addr1=1314, addr2=2423, addr3=2221; row_done on addr1 and addr3; done with addr3 write.
REQ-049 Same stimulus with ORDER=1 -> writes addr0=1112, addr1=1314, addr3=2324, addr2=2122.
REQ-050 Same stimulus with in_valid low on every other cycle -> identical write sequence; with FMAP_STALL_CNT_EN, stall_cnt=7 at done.
REQ-051 abort asserted in the cycle the third beat is accepted -> exactly one write (addr0); busy=0 next cycle; a new start rewrites from addr0.
REQ-052 rst_n pulled low between clock edges mid-row -> cen=1 and busy=0 immediately; no write on the following edge.
REQ-053 start pulsed again during a frame -> ignored; write count stays ROWS*COLS/2.
